// File: rtl/ttl_out_cmd_sender_if.sv
// UART transmit handshake between the command sender (master) and the UART (slave).
// The UART raises busy after accepting a one-cycle en pulse and drops it when the byte is out.
`timescale 1ns/1ps
interface ttl_out_cmd_sender_if;
    logic       uart_en;
    logic [7:0] uart_data;
    logic       uart_busy;

    modport master (
        output uart_en,
        output uart_data,
        input  uart_busy
    );

    modport slave (
        input  uart_en,
        input  uart_data,
        output uart_busy
    );
endinterface

// File: rtl/ttl_out_cmd_sender.sv
// Sends two-byte LED commands ('a'/'b' then '1'..'4') for each state_in bit that differs from the remote copy; optional CMD_SENDER_RESYNC_EN adds a resync port.
// Latency: uart_en is asserted the cycle after a change is seen in IDLE; one command at a time, lowest LED first.
// Backpressure: waits for uart_busy to rise then fall per byte; if busy never rises, START_TIMEOUT cycles count as sent.
`timescale 1ns/1ps
module ttl_out_cmd_sender #(
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [3:0]                    state_in,
`ifdef CMD_SENDER_RESYNC_EN
    input  logic                          resync,
`endif
    output logic                          cmd_busy,
    ttl_out_cmd_sender_if.master          uart
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(START_TIMEOUT);

    state_t     state_q;
    logic       byte_sel_q;
    logic [7:0] cnt_q;
    logic [3:0] sent_state_q;
    logic [1:0] idx_q;
    logic       pol_q;
    logic       uart_en_q;
    logic [7:0] uart_data_q;

    logic [3:0] pending_mask;
    logic [3:0] dirty_d;
    logic [1:0] dirty_idx_d;
    logic       byte_done_d;

`ifdef CMD_SENDER_RESYNC_EN
    logic [3:0] pending_resync_q;
    assign pending_mask = pending_resync_q;
`else
    assign pending_mask = 4'b0000;
`endif

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [7:0] opcode_byte(input logic pol);
        return pol ? 8'h61 : 8'h62;
    endfunction

    always_comb begin
        dirty_d     = (state_in ^ sent_state_q) | pending_mask;
        dirty_idx_d = lowest_idx(dirty_d);
        byte_done_d = 1'b0;
        // A rising busy in WAIT_START wins over the timeout on the same cycle.
        case (state_q)
            WAIT_START: byte_done_d = !uart.uart_busy && ((cnt_q + 8'd1) == TIMEOUT_C);
            WAIT_DONE:  byte_done_d = !uart.uart_busy;
            default:    byte_done_d = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= IDLE;
            byte_sel_q       <= 1'b0;
            cnt_q            <= 8'd0;
            sent_state_q     <= 4'b0000;
            idx_q            <= 2'd0;
            pol_q            <= 1'b0;
            uart_en_q        <= 1'b0;
            uart_data_q      <= 8'h00;
`ifdef CMD_SENDER_RESYNC_EN
            pending_resync_q <= 4'b0000;
`endif
        end else begin
            uart_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|dirty_d) begin
                        idx_q       <= dirty_idx_d;
                        pol_q       <= state_in[dirty_idx_d];
                        byte_sel_q  <= 1'b0;
                        uart_en_q   <= 1'b1;
                        uart_data_q <= opcode_byte(state_in[dirty_idx_d]);
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    cnt_q   <= 8'd0;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (uart.uart_busy) state_q <= WAIT_DONE;
                    else                cnt_q   <= cnt_q + 8'd1;
                end
                default: ;
            endcase

            // Completion of a byte overrides the per-state transitions above.
            if (byte_done_d) begin
                if (!byte_sel_q) begin
                    byte_sel_q  <= 1'b1;
                    uart_en_q   <= 1'b1;
                    uart_data_q <= 8'h31 + {6'd0, idx_q};
                    state_q     <= SEND;
                end else begin
                    sent_state_q[idx_q] <= pol_q;
`ifdef CMD_SENDER_RESYNC_EN
                    pending_resync_q[idx_q] <= 1'b0;
`endif
                    state_q <= IDLE;
                end
            end

`ifdef CMD_SENDER_RESYNC_EN
            if (resync) pending_resync_q <= 4'b1111;
`endif
        end
    end

    assign uart.uart_en   = uart_en_q;
    assign uart.uart_data = uart_data_q;
    assign cmd_busy       = (state_q != IDLE);

endmodule
